// File: rtl/sram_rw_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_rw_arbiter_if
//
// Requester-side bus of the SRAM read/write-port arbiter. Every per-requester
// field is flattened, with requester i in slice i.
//
//   req_valid  [NUM_REQ]             request present
//   req_ready  [NUM_REQ]             request accepted this cycle (one-hot/zero)
//   req_we     [NUM_REQ]             1 = write, 0 = read
//   req_wmask  [NUM_REQ*NUM_WMASKS]  byte enables (writes only)
//   req_addr   [NUM_REQ*ADDR_WIDTH]  word address
//   req_wdata  [NUM_REQ*DATA_WIDTH]  write data
//   rsp_valid  [NUM_REQ]             one-cycle response pulse (one-hot/zero)
//   rsp_we                           response is a write ack (1) / read data (0)
//   rsp_rdata  [DATA_WIDTH]          read data, shared by all requesters
//
// master: the requester side.  slave: the arbiter.
// ---------------------------------------------------------------------------
interface sram_rw_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*NUM_WMASKS-1:0] req_wmask;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic                          rsp_we;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );

endinterface

// File: rtl/sram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// sram_rw_arbiter
//
// Round-robin arbiter and sequencer sharing the read/write port (port 0) of a
// 32x512 OpenRAM macro between NUM_REQ requesters. One request is accepted
// per cycle, the macro command is registered onto the sram_* pins, and the
// read data / write acknowledgement returns to the originating requester two
// cycles after the accept edge.
//
// Ports:
//   wb_clk_i     single clock (also the macro clk0 at top level)
//   wb_rst_i     synchronous, active-high reset
//   bus          requester bus (sram_rw_arbiter_if.slave)
//   sram_csb0    macro chip select, active low
//   sram_web0    macro write enable, active low
//   sram_wmask0  macro byte mask (driven 0 on reads)
//   sram_addr0   macro word address
//   sram_din0    macro write data
//   sram_dout0   macro read data
//
// Pipeline (T0 = accept edge):
//   T0  command registered onto the sram_* pins, tag/we kept alongside
//   T1  macro captures the pins; stage C records that it holds a command
//   --  macro drives dout0 after the falling edge following T1
//   T2  stage R registers dout0 (reads) and raises rsp_valid for one cycle
// ---------------------------------------------------------------------------
module sram_rw_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  sram_rw_arbiter_if.slave      bus,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Arbitration
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  found;
  logic                  xfer;
  logic [PTR_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    grant_vec;
  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Command stage (the macro pins plus the matching tag)
  logic                  sram_csb0_q, sram_csb0_d;
  logic                  sram_web0_q, sram_web0_d;
  logic [NUM_WMASKS-1:0] sram_wmask0_q, sram_wmask0_d;
  logic [ADDR_WIDTH-1:0] sram_addr0_q, sram_addr0_d;
  logic [DATA_WIDTH-1:0] sram_din0_q, sram_din0_d;
  logic [PTR_W-1:0]      cmd_tag_q, cmd_tag_d;
  logic                  cmd_we_q, cmd_we_d;

  // Stage C: the macro holds a captured command
  logic                  v_c_q, v_c_d;
  logic [PTR_W-1:0]      tag_c_q, tag_c_d;
  logic                  we_c_q, we_c_d;

  // Stage R: response registers
  logic                  v_r_q, v_r_d;
  logic [PTR_W-1:0]      tag_r_q, tag_r_d;
  logic                  we_r_q, we_r_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]    rsp_valid_vec;

  // Two passes implement the wrap-around search: first the indices at or
  // above ptr, then (only if none was found) the indices below it.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i] && (PTR_W'(i) >= ptr_q)) begin
        found     = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found     = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end

    // Nothing is accepted while reset is held.
    xfer = found && !wb_rst_i;

    grant_vec = '0;
    sel_we    = 1'b0;
    sel_wmask = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_vec[i] = xfer && (grant_idx == PTR_W'(i));
      if (grant_idx == PTR_W'(i)) begin
        sel_we    = bus.req_we[i];
        sel_wmask = bus.req_wmask[i*NUM_WMASKS +: NUM_WMASKS];
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d         = ptr_q;
    sram_csb0_d   = 1'b1;
    sram_web0_d   = 1'b1;
    sram_wmask0_d = sram_wmask0_q;
    sram_addr0_d  = sram_addr0_q;
    sram_din0_d   = sram_din0_q;
    cmd_tag_d     = cmd_tag_q;
    cmd_we_d      = cmd_we_q;

    if (xfer) begin
      ptr_d         = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      sram_csb0_d   = 1'b0;
      sram_web0_d   = ~sel_we;
      // The macro ignores wmask on reads; zero keeps the pins from toggling.
      sram_wmask0_d = sel_we ? sel_wmask : '0;
      sram_addr0_d  = sel_addr;
      sram_din0_d   = sel_wdata;
      cmd_tag_d     = grant_idx;
      cmd_we_d      = sel_we;
    end

    // An active chip select on the pins is exactly the command the macro
    // captures on the next edge.
    v_c_d   = ~sram_csb0_q;
    tag_c_d = cmd_tag_q;
    we_c_d  = cmd_we_q;

    v_r_d   = v_c_q;
    tag_r_d = tag_c_q;
    we_r_d  = we_c_q;
    // dout0 settles after the falling edge following capture, so it is
    // sampled one edge after stage C; it holds across write acks.
    rsp_rdata_d = (v_c_q && !we_c_q) ? sram_dout0 : rsp_rdata_q;
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (wb_rst_i) begin
      ptr_q         <= '0;
      sram_csb0_q   <= 1'b1;
      sram_web0_q   <= 1'b1;
      sram_wmask0_q <= '0;
      sram_addr0_q  <= '0;
      sram_din0_q   <= '0;
      cmd_tag_q     <= '0;
      cmd_we_q      <= 1'b0;
      v_c_q         <= 1'b0;
      tag_c_q       <= '0;
      we_c_q        <= 1'b0;
      v_r_q         <= 1'b0;
      tag_r_q       <= '0;
      we_r_q        <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      ptr_q         <= ptr_d;
      sram_csb0_q   <= sram_csb0_d;
      sram_web0_q   <= sram_web0_d;
      sram_wmask0_q <= sram_wmask0_d;
      sram_addr0_q  <= sram_addr0_d;
      sram_din0_q   <= sram_din0_d;
      cmd_tag_q     <= cmd_tag_d;
      cmd_we_q      <= cmd_we_d;
      v_c_q         <= v_c_d;
      tag_c_q       <= tag_c_d;
      we_c_q        <= we_c_d;
      v_r_q         <= v_r_d;
      tag_r_q       <= tag_r_d;
      we_r_q        <= we_r_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  always_comb begin
    rsp_valid_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_vec[i] = v_r_q && (tag_r_q == PTR_W'(i));
    end
  end

  assign bus.req_ready = grant_vec;
  assign bus.rsp_valid = rsp_valid_vec;
  assign bus.rsp_we    = we_r_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign sram_csb0   = sram_csb0_q;
  assign sram_web0   = sram_web0_q;
  assign sram_wmask0 = sram_wmask0_q;
  assign sram_addr0  = sram_addr0_q;
  assign sram_din0   = sram_din0_q;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_rw_arbiter
//
// Directed bench for sram_rw_arbiter with a behavioural OpenRAM port-0 model
// (capture on the rising edge, access on the following falling edge).
// Accepted requests are pushed to a scoreboard with their due cycle and
// expected data; every clock step pops and compares the response.
// ---------------------------------------------------------------------------
module tb_sram_rw_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 9;
  localparam int DW      = 32;
  localparam int NW      = 4;
  localparam int DEPTH   = 1 << AW;

  typedef struct {
    int            tag;
    logic          we;
    logic [DW-1:0] rdata;
    int            due;
  } exp_t;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          sram_csb0;
  logic          sram_web0;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   m_ptr  = 0;

  sram_rw_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)
  ) bus ();

  sram_rw_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .bus         (bus),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [DW-1:0] init_word(input int a);
    return (32'(a) * 32'h0001_0003) ^ 32'hA5A5_0000;
  endfunction

  // Macro port 0: inputs captured on the rising edge, array accessed on the
  // following falling edge; dout holds between reads.
  initial begin : sram_model
    logic          c;
    logic          w;
    logic [NW-1:0] m;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) sram_mem[i] = init_word(i);
    sram_mem[5] = 32'hDEAD_BEEF;
    sram_mem[7] = 32'hAAAA_AAAA;
    sram_dout0  = '0;
    forever begin
      @(posedge wb_clk_i);
      c = sram_csb0; w = sram_web0; m = sram_wmask0; a = sram_addr0; d = sram_din0;
      @(negedge wb_clk_i);
      if (c === 1'b0) begin
        if (w === 1'b0) begin
          for (int b = 0; b < NW; b++)
            if (m[b]) sram_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end else begin
          sram_dout0 = sram_mem[a];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] rr_expect(input logic [NUM_REQ-1:0] v);
    logic [NUM_REQ-1:0] g = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx = (m_ptr + k) % NUM_REQ;
      if (g == '0 && v[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  task automatic set_req(input int i, input logic we, input logic [NW-1:0] wm,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]            = 1'b1;
    bus.req_we[i]               = we;
    bus.req_wmask[i*NW +: NW]   = wm;
    bus.req_addr[i*AW +: AW]    = a;
    bus.req_wdata[i*DW +: DW]   = d;
  endtask

  // One clock cycle: check the response due now, check the grant, record the
  // accepted requests, then advance past the rising edge.
  task automatic step(input logic [NUM_REQ-1:0] exp_ready);
    logic [NUM_REQ-1:0] exp_v;
    @(negedge wb_clk_i);
    exp_v = '0;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      exp_t e = sb.pop_front();
      exp_v[e.tag] = 1'b1;
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
      check("rsp_we", 64'(bus.rsp_we), 64'(e.we));
      if (!e.we) check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
    end else begin
      check("rsp_valid_idle", 64'(bus.rsp_valid), 64'(exp_v));
    end
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_ready[i]) begin
        exp_t          e;
        logic [AW-1:0] a  = bus.req_addr[i*AW +: AW];
        logic [NW-1:0] wm = bus.req_wmask[i*NW +: NW];
        logic [DW-1:0] d  = bus.req_wdata[i*DW +: DW];
        e.tag = i;
        e.we  = bus.req_we[i];
        e.due = cyc + 3;
        e.rdata = '0;
        if (e.we) begin
          for (int b = 0; b < NW; b++)
            if (wm[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end else begin
          e.rdata = ref_mem[a];
        end
        sb.push_back(e);
        m_ptr = (i + 1) % NUM_REQ;
      end
    end
    @(posedge wb_clk_i);
    #1;
    cyc++;
    bus.req_valid = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_csb0", 64'(sram_csb0), 64'(1'b1));
    check("rst_web0", 64'(sram_web0), 64'(1'b1));
    check("rst_wmask0", 64'(sram_wmask0), 64'(0));
    check("rst_addr0", 64'(sram_addr0), 64'(0));
    check("rst_din0", 64'(sram_din0), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_rsp_we", 64'(bus.rsp_we), 64'(0));
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step('0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    ref_mem[5] = 32'hDEAD_BEEF;
    ref_mem[7] = 32'hAAAA_AAAA;
    wb_rst_i      = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_wmask = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset: requests are refused while reset is held.
    bus.req_valid = '1;
    step('0);
    bus.req_valid = '1;
    step('0);
    check_reset_outputs();
    wb_rst_i = 1'b0;
    m_ptr    = 0;

    // Single read of a preloaded word.
    set_req(0, 1'b0, 4'hF, 9'd5, '0);
    step(2'b01);
    check("read_wmask0", 64'(sram_wmask0), 64'(0));
    check("read_csb0", 64'(sram_csb0), 64'(0));
    drain(3);

    // Byte-masked write then read back by requester 1.
    set_req(1, 1'b1, 4'b0101, 9'd7, 32'h1122_3344);
    step(2'b10);
    check("wr_pins", {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
          {1'b0, 1'b0, 4'b0101, 9'd7, 32'h1122_3344});
    set_req(1, 1'b0, 4'hF, 9'd7, '0);
    step(2'b10);
    drain(3);
    check("masked_write_model", 64'(ref_mem[7]), 64'(32'hAA22_AA44));

    // Fairness: both requesters hold valid for six cycles.
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1'b0, 4'hF, AW'(10 + k), '0);
      set_req(1, 1'b0, 4'hF, AW'(20 + k), '0);
      step((k % 2 == 0) ? 2'b01 : 2'b10);
    end
    drain(3);

    // Write then read of the same address on consecutive cycles.
    set_req(0, 1'b1, 4'hF, 9'd511, 32'hCAFE_F00D);
    step(2'b01);
    set_req(0, 1'b0, 4'hF, 9'd511, '0);
    step(2'b01);
    drain(3);

    // Idle: the macro stays deselected and the pointer holds.
    for (int k = 0; k < 10; k++) begin
      step('0);
      check("idle_csb_web", 64'({sram_csb0, sram_web0}), 64'(2'b11));
    end
    bus.req_valid = '1;
    step(2'b10);
    drain(3);

    // Mixed random traffic on a small address window.
    for (int k = 0; k < 24; k++) begin
      logic [NUM_REQ-1:0] v = NUM_REQ'($urandom_range(0, 3));
      for (int i = 0; i < NUM_REQ; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), NW'($urandom_range(0, 15)),
                AW'($urandom_range(0, 15)), $urandom());
        bus.req_valid[i] = v[i];
      end
      step(rr_expect(v));
    end
    drain(3);

    // Reset one edge after accepting a read: that read never responds.
    set_req(0, 1'b0, 4'hF, 9'd5, '0);
    step(2'b01);
    wb_rst_i = 1'b1;
    sb.delete();
    m_ptr = 0;
    bus.req_valid = '1;
    step('0);
    check_reset_outputs();
    bus.req_valid = '1;
    step('0);
    wb_rst_i = 1'b0;
    drain(4);
    check("post_rst_csb0", 64'(sram_csb0), 64'(1'b1));
    bus.req_valid = '1;
    set_req(0, 1'b0, 4'hF, 9'd5, '0);
    set_req(1, 1'b0, 4'hF, 9'd7, '0);
    step(2'b01);
    drain(3);

    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
